// File: rtl/gpr_wb_arb_if.sv
// Writeback request channels from the alu, lsu and csr units into the
// GPR writeback arbiter. master = requesting units, slave = arbiter.
interface gpr_wb_arb_if;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned DATA_W = 32;

  logic              alu_valid;
  logic [IDX_W-1:0]  alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              lsu_valid;
  logic [IDX_W-1:0]  lsu_rd;
  logic [DATA_W-1:0] lsu_data;
  logic              lsu_ready;

  logic              csr_valid;
  logic [IDX_W-1:0]  csr_rd;
  logic [DATA_W-1:0] csr_data;
  logic              csr_ready;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output csr_valid, csr_rd, csr_data,
    input  alu_ready, lsu_ready, csr_ready
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  csr_valid, csr_rd, csr_data,
    output alu_ready, lsu_ready, csr_ready
  );
endinterface

// File: rtl/gpr_wb_arb.sv
// GPR writeback arbiter with register scoreboard.
// Round-robin grant among alu/lsu/csr, one registered GPR write per cycle,
// busy bits set at issue and cleared at writeback.
// Optional macro GPR_WB_FWD_EN adds write-port to decode forwarding.
module gpr_wb_arb (
  input  logic         clk,
  input  logic         rstn,
  gpr_wb_arb_if.slave  wb,
  input  logic         issue_valid,
  input  logic [4:0]   issue_rd,
  input  logic [4:0]   rs1_idx,
  input  logic [4:0]   rs2_idx,
  output logic         rs1_busy,
  output logic         rs2_busy,
  output logic         gpr_wr_en,
  output logic [4:0]   gpr_wr_idx,
  output logic [31:0]  gpr_wr_data,
  output logic [31:0]  busy_vec,
  output logic         fwd_rs1_valid,
  output logic         fwd_rs2_valid,
  output logic [31:0]  fwd_rs1_data,
  output logic [31:0]  fwd_rs2_data
);

  localparam int unsigned NREQ   = 3;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] SEL_ALU = 2'd0;
  localparam logic [1:0] SEL_LSU = 2'd1;
  localparam logic [1:0] SEL_CSR = 2'd2;

  logic [NREQ-1:0]   req;
  logic [1:0]        ptr;
  logic [1:0]        order [NREQ];
  logic              gnt_any;
  logic [1:0]        gnt_idx;
  logic [IDX_W-1:0]  gnt_rd;
  logic [DATA_W-1:0] gnt_data;
  logic              wb_wr;
  logic [31:0]       busy_nxt;

  // Requests are masked while reset is held so no ready can rise.
  assign req = {wb.csr_valid, wb.lsu_valid, wb.alu_valid} & {NREQ{rstn}};

  // Search order starting at the round-robin pointer.
  always_comb begin
    order[0] = SEL_ALU;
    order[1] = SEL_LSU;
    order[2] = SEL_CSR;
    case (ptr)
      SEL_LSU: begin
        order[0] = SEL_LSU;
        order[1] = SEL_CSR;
        order[2] = SEL_ALU;
      end
      SEL_CSR: begin
        order[0] = SEL_CSR;
        order[1] = SEL_ALU;
        order[2] = SEL_LSU;
      end
      default: ;
    endcase
  end

  // First valid requester in search order wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = SEL_ALU;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!gnt_any && req[order[k]]) begin
        gnt_any = 1'b1;
        gnt_idx = order[k];
      end
    end
  end

  // Payload of the granted requester.
  always_comb begin
    gnt_rd   = wb.alu_rd;
    gnt_data = wb.alu_data;
    case (gnt_idx)
      SEL_LSU: begin
        gnt_rd   = wb.lsu_rd;
        gnt_data = wb.lsu_data;
      end
      SEL_CSR: begin
        gnt_rd   = wb.csr_rd;
        gnt_data = wb.csr_data;
      end
      default: ;
    endcase
  end

  assign wb.alu_ready = gnt_any && (gnt_idx == SEL_ALU);
  assign wb.lsu_ready = gnt_any && (gnt_idx == SEL_LSU);
  assign wb.csr_ready = gnt_any && (gnt_idx == SEL_CSR);

  // x0 writebacks complete the handshake but never reach the register file.
  assign wb_wr = gnt_any && (gnt_rd != '0);

  // Scoreboard update: clear on writeback, then set on issue so set wins.
  always_comb begin
    busy_nxt = busy_vec;
    if (wb_wr) begin
      busy_nxt[gnt_rd] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      busy_nxt[issue_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Pointer, write port and scoreboard registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr         <= SEL_ALU;
      gpr_wr_en   <= 1'b0;
      gpr_wr_idx  <= '0;
      gpr_wr_data <= '0;
      busy_vec    <= '0;
    end else begin
      gpr_wr_en <= wb_wr;
      if (wb_wr) begin
        gpr_wr_idx  <= gnt_rd;
        gpr_wr_data <= gnt_data;
      end
      busy_vec <= busy_nxt;
      if (gnt_any) begin
        ptr <= (gnt_idx == SEL_CSR) ? SEL_ALU : gnt_idx + 2'd1;
      end
    end
  end

  assign rs1_busy = busy_vec[rs1_idx];
  assign rs2_busy = busy_vec[rs2_idx];

`ifdef GPR_WB_FWD_EN
  // Forward the value currently on the write port to matching sources.
  always_comb begin
    fwd_rs1_valid = gpr_wr_en && (rs1_idx != '0) && (gpr_wr_idx == rs1_idx);
    fwd_rs2_valid = gpr_wr_en && (rs2_idx != '0) && (gpr_wr_idx == rs2_idx);
    fwd_rs1_data  = fwd_rs1_valid ? gpr_wr_data : '0;
    fwd_rs2_data  = fwd_rs2_valid ? gpr_wr_data : '0;
  end
`else
  assign fwd_rs1_valid = 1'b0;
  assign fwd_rs2_valid = 1'b0;
  assign fwd_rs1_data  = '0;
  assign fwd_rs2_data  = '0;
`endif

endmodule

// File: tb/tb_gpr_wb_arb.sv
// Bench for gpr_wb_arb: directed scenarios plus random traffic, checked
// against a round-robin / scoreboard reference model with a write queue.
module tb_gpr_wb_arb;

  logic        clk;
  logic        rstn;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        gpr_wr_en;
  logic [4:0]  gpr_wr_idx;
  logic [31:0] gpr_wr_data;
  logic [31:0] busy_vec;
  logic        fwd_rs1_valid;
  logic        fwd_rs2_valid;
  logic [31:0] fwd_rs1_data;
  logic [31:0] fwd_rs2_data;

  gpr_wb_arb_if wb ();

  gpr_wb_arb dut (
    .clk           (clk),
    .rstn          (rstn),
    .wb            (wb.slave),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .rs1_idx       (rs1_idx),
    .rs2_idx       (rs2_idx),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
    .gpr_wr_en     (gpr_wr_en),
    .gpr_wr_idx    (gpr_wr_idx),
    .gpr_wr_data   (gpr_wr_data),
    .busy_vec      (busy_vec),
    .fwd_rs1_valid (fwd_rs1_valid),
    .fwd_rs2_valid (fwd_rs2_valid),
    .fwd_rs1_data  (fwd_rs1_data),
    .fwd_rs2_data  (fwd_rs2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [4:0]  idx;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  cyc   = 0;
  int  tests = 0;
  int  fails = 0;

  // Reference model state
  int          rr;
  bit          busy_m [32];
  bit          pw_v;
  logic [4:0]  pw_i;
  logic [31:0] pw_d;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    rr   = 0;
    pw_v = 1'b0;
    pw_i = '0;
    pw_d = '0;
    for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
  endtask

  function automatic logic [31:0] busy_pack();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = busy_m[i];
    return v;
  endfunction

  // Write-port monitor: every cycle either the next queued write is due or
  // the port must be idle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      chk("missed_write", 32'(exp_q[0].idx), 32'hFFFF_FFFF);
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      chk("wr_en", 32'(gpr_wr_en), 32'd1);
      chk("wr_idx", 32'(gpr_wr_idx), 32'(exp_q[0].idx));
      chk("wr_data", gpr_wr_data, exp_q[0].data);
      void'(exp_q.pop_front());
    end else begin
      chk("wr_en_idle", 32'(gpr_wr_en), 32'd0);
    end
  end

  // One cycle: drive at negedge, check combinational/state outputs, then
  // advance the model across the coming rising edge.
  task automatic step(input logic [2:0] v,
                      input logic [4:0] rd0, input logic [4:0] rd1, input logic [4:0] rd2,
                      input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                      input logic iv, input logic [4:0] ird,
                      input logic [4:0] r1, input logic [4:0] r2);
    logic [4:0]  rds [3];
    logic [31:0] ds  [3];
    int          win;
    int          c;
    logic        e1v, e2v;
    @(negedge clk);
    wb.alu_valid = v[0]; wb.alu_rd = rd0; wb.alu_data = d0;
    wb.lsu_valid = v[1]; wb.lsu_rd = rd1; wb.lsu_data = d1;
    wb.csr_valid = v[2]; wb.csr_rd = rd2; wb.csr_data = d2;
    issue_valid = iv; issue_rd = ird;
    rs1_idx = r1; rs2_idx = r2;
    #1;
    rds[0] = rd0; rds[1] = rd1; rds[2] = rd2;
    ds[0]  = d0;  ds[1]  = d1;  ds[2]  = d2;
    win = -1;
    for (int k = 0; k < 3; k++) begin
      c = (rr + k) % 3;
      if (win < 0 && v[c]) win = c;
    end
    chk("alu_ready", 32'(wb.alu_ready), 32'(win == 0));
    chk("lsu_ready", 32'(wb.lsu_ready), 32'(win == 1));
    chk("csr_ready", 32'(wb.csr_ready), 32'(win == 2));
    chk("busy_vec", busy_vec, busy_pack());
    chk("rs1_busy", 32'(rs1_busy), 32'(busy_m[r1]));
    chk("rs2_busy", 32'(rs2_busy), 32'(busy_m[r2]));
`ifdef GPR_WB_FWD_EN
    e1v = pw_v && (r1 != 0) && (pw_i == r1);
    e2v = pw_v && (r2 != 0) && (pw_i == r2);
`else
    e1v = 1'b0;
    e2v = 1'b0;
`endif
    chk("fwd_rs1_valid", 32'(fwd_rs1_valid), 32'(e1v));
    chk("fwd_rs2_valid", 32'(fwd_rs2_valid), 32'(e2v));
    chk("fwd_rs1_data", fwd_rs1_data, e1v ? pw_d : 32'd0);
    chk("fwd_rs2_data", fwd_rs2_data, e2v ? pw_d : 32'd0);
    // Model advance
    pw_v = 1'b0;
    if (win >= 0) begin
      rr = (win + 1) % 3;
      if (rds[win] != 0) begin
        exp_q.push_back('{cyc: cyc + 1, idx: rds[win], data: ds[win]});
        busy_m[rds[win]] = 1'b0;
        pw_v = 1'b1;
        pw_i = rds[win];
        pw_d = ds[win];
      end
    end
    if (iv && ird != 0) busy_m[ird] = 1'b1;
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    step(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, r1, r2);
  endtask

  task automatic clear_inputs();
    wb.alu_valid = 1'b0; wb.alu_rd = '0; wb.alu_data = '0;
    wb.lsu_valid = 1'b0; wb.lsu_rd = '0; wb.lsu_data = '0;
    wb.csr_valid = 1'b0; wb.csr_rd = '0; wb.csr_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
    rs1_idx = '0; rs2_idx = '0;
  endtask

  task automatic reset_checks();
    chk("rst_wr_en", 32'(gpr_wr_en), 32'd0);
    chk("rst_wr_idx", 32'(gpr_wr_idx), 32'd0);
    chk("rst_wr_data", gpr_wr_data, 32'd0);
    chk("rst_busy_vec", busy_vec, 32'd0);
    chk("rst_alu_ready", 32'(wb.alu_ready), 32'd0);
    chk("rst_lsu_ready", 32'(wb.lsu_ready), 32'd0);
    chk("rst_csr_ready", 32'(wb.csr_ready), 32'd0);
    chk("rst_fwd", {fwd_rs1_data[15:0], fwd_rs2_data[13:0], fwd_rs1_valid, fwd_rs2_valid}, 32'd0);
  endtask

  logic [2:0]  rv;
  logic        riv;
  logic [4:0]  rird;

  initial begin
    clear_inputs();
    model_reset();
    rstn = 1'b1;
    #1 rstn = 1'b0;
    // Requests held high during reset must not be granted
    wb.alu_valid = 1'b1; wb.lsu_valid = 1'b1; wb.csr_valid = 1'b1;
    #1;
    reset_checks();
    @(negedge clk);
    @(negedge clk);
    clear_inputs();
    rstn = 1'b1;

    // Six cycles of all three requesting: alu, lsu, csr, alu, lsu, csr
    for (int i = 0; i < 6; i++)
      step(3'b111, 5'd1, 5'd2, 5'd3, 32'h100 + 32'(i), 32'h200 + 32'(i), 32'h300 + 32'(i),
           1'b0, 5'd0, 5'd0, 5'd0);
    idle(5'd0, 5'd0);

    // Issue x5, lsu writes it back three cycles later
    step(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 5'd5, 5'd5, 5'd0);
    idle(5'd5, 5'd0);
    idle(5'd5, 5'd0);
    step(3'b010, 5'd0, 5'd5, 5'd0, 32'd0, 32'hDEADBEEF, 32'd0, 1'b0, 5'd0, 5'd5, 5'd5);
    idle(5'd5, 5'd5);
    idle(5'd5, 5'd0);

    // Issue x7 and writeback to x7 in the same cycle: set wins
    step(3'b001, 5'd7, 5'd0, 5'd0, 32'h7777_0007, 32'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd0);
    idle(5'd7, 5'd7);
    idle(5'd7, 5'd0);

    // Writeback to x0: handshake only
    step(3'b001, 5'd0, 5'd0, 5'd0, 32'h1234, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    idle(5'd0, 5'd0);

    // Write x3 while decode reads x3 on rs2
    step(3'b100, 5'd0, 5'd0, 5'd3, 32'd0, 32'd0, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd0, 5'd3);
    idle(5'd0, 5'd3);
    idle(5'd3, 5'd3);

    // Reset the cycle after a grant
    step(3'b111, 5'd9, 5'd10, 5'd11, 32'h9, 32'hA, 32'hB, 1'b1, 5'd12, 5'd0, 5'd0);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    clear_inputs();
    model_reset();
    exp_q.delete();
    #1;
    reset_checks();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    step(3'b111, 5'd1, 5'd2, 5'd3, 32'hA1, 32'hB2, 32'hC3, 1'b0, 5'd0, 5'd0, 5'd0);
    step(3'b111, 5'd1, 5'd2, 5'd3, 32'hA1, 32'hB2, 32'hC3, 1'b0, 5'd0, 5'd0, 5'd0);
    idle(5'd0, 5'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rv   = 3'($urandom_range(0, 7));
      riv  = 1'($urandom_range(0, 1));
      rird = 5'($urandom_range(0, 7));
      if (busy_m[rird]) riv = 1'b0;
      step(rv,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           $urandom, $urandom, $urandom,
           riv, rird,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(5'd0, 5'd0);
    idle(5'd0, 5'd0);
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gpr_wb_arb.md
GPR_WB_ARB -- requirements
Module: gpr_wb_arb

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-002 SHALL have port rstn, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have ports <r>_valid, input, 1 each, <r> in {alu, lsu, csr}; writeback request.
REQ-004 SHALL have ports <r>_rd, input, 5 each; destination register index.
REQ-005 SHALL have ports <r>_data, input, 32 each; writeback data.
REQ-006 SHALL have ports <r>_ready, output, 1 each; grant, handshake when valid and ready both high.
REQ-007 SHALL have port issue_valid, input, 1; an instruction with a destination register issues this cycle.
REQ-008 SHALL have port issue_rd, input, 5; destination of the issuing instruction.
REQ-009 SHALL have ports rs1_idx and rs2_idx, input, 5 each; source indices being read by decode.
REQ-010 SHALL have ports rs1_busy and rs2_busy, output, 1 each; source has a pending writeback.
REQ-011 SHALL have port gpr_wr_en, output, 1; GPR write strobe.
REQ-012 SHALL have port gpr_wr_idx, output, 5; GPR write index.
REQ-013 SHALL have port gpr_wr_data, output, 32; GPR write data.
REQ-014 SHALL have port busy_vec, output, 32; scoreboard state.
REQ-015 SHALL have ports fwd_rs1_valid and fwd_rs2_valid, output, 1 each; forwarding hit.
REQ-016 SHALL have ports fwd_rs1_data and fwd_rs2_data, output, 32 each; forwarded data.

Function
REQ-017 SHALL grant at most one requester per cycle; <r>_ready is combinational and high only if <r>_valid is high.
REQ-018 SHALL arbitrate round-robin in fixed order alu -> lsu -> csr -> alu, starting the search at a 2-bit pointer.
REQ-019 SHALL, after a grant, move the pointer to the requester following the granted one; with no grant the pointer holds.
REQ-020 SHALL register the granted request: grant in cycle N -> gpr_wr_en=1 with that rd/data in cycle N+1, for exactly one cycle.
REQ-021 SHALL keep gpr_wr_en=0 in any cycle following a cycle with no grant; gpr_wr_idx/gpr_wr_data then hold their last values.
REQ-022 SHALL handshake requests with rd=0 normally but never assert gpr_wr_en for them, and leave busy_vec unaffected.
REQ-023 SHALL set busy_vec[issue_rd] at the clock edge ending a cycle with issue_valid=1 and issue_rd!=0.
REQ-024 SHALL clear busy_vec[rd] at the edge that registers a granted writeback with rd!=0.
REQ-025 SHALL let set win when set and clear target the same index at the same edge.
REQ-026 SHALL hold busy_vec[0]=0 at all times.
REQ-027 SHALL drive rsN_busy = busy_vec[rsN_idx] combinationally; rsN_idx=0 gives 0.
REQ-028 SHALL accept writebacks to non-busy registers, writing them without changing busy_vec.
REQ-029 SHALL never see issue to an already-busy rd, because upstream stalls on it; behaviour in that case is unspecified.

Reset
REQ-030 SHALL, on rstn low, asynchronously clear gpr_wr_en, gpr_wr_idx, gpr_wr_data, busy_vec and all fwd outputs, and set the pointer to alu.
REQ-031 SHALL hold all <r>_ready at 0 while rstn is low.
REQ-032 SHALL discard any registered but unwritten writeback on reset mid-operation; after release, no gpr_wr_en occurs until a new grant.

Configuration
REQ-033 SHALL, with macro GPR_WB_FWD_EN defined, drive fwd_rsN_valid=1 and fwd_rsN_data=gpr_wr_data whenever gpr_wr_en=1 and gpr_wr_idx==rsN_idx!=0 (combinational), else valid=0 and data=0.
REQ-034 SHALL, without GPR_WB_FWD_EN, tie fwd_rs1_valid, fwd_rs2_valid, fwd_rs1_data and fwd_rs2_data to 0, with no forwarding logic present.

Verification
REQ-035 SHALL cover: alu, lsu and csr all valid for 6 cycles starting from pointer=alu -> grants alu, lsu, csr, alu, lsu, csr; gpr_wr_en high in each following cycle.
REQ-036 SHALL cover: issue_valid with issue_rd=5, then lsu writes rd=5 data 0xDEADBEEF 3 cycles later -> busy_vec[5]=1 until the registering edge, then 0; rs1_idx=5 gives rs1_busy 1 then 0.
REQ-037 SHALL cover: issue rd=7 and a writeback grant for rd=7 in the same cycle -> busy_vec[7]=1 afterwards and gpr_wr_en=1 with idx 7.
REQ-038 SHALL cover: alu_valid with rd=0 and data 0x1234 -> alu_ready=1, gpr_wr_en stays 0, busy_vec unchanged.
REQ-039 SHALL cover: with GPR_WB_FWD_EN, a write of rd=3 data 0xA5A5A5A5 while rs2_idx=3 -> fwd_rs2_valid=1 and fwd_rs2_data=0xA5A5A5A5 in the gpr_wr_en cycle; without the macro -> 0 and 0.
REQ-040 SHALL cover: rstn pulsed low the cycle after a grant -> no gpr_wr_en, busy_vec=0, and the next simultaneous requests are granted to alu first.
